aurora_reset_seq: RTL and testbench

Parametrised reset/bring-up sequencer for an Aurora link, running on `init_clk`. It drives `tx_reset` and `gt_reset` through a programmable power-on sequence and issues a `start` pulse to downstream logic. It then watches `channel_up` and re-runs the sequence on timeout, up to a bounded retry count, before declaring failure. It sits between board reset and the Aurora core's reset pins.

---
 rtl/aurora_reset_seq.sv | 184 ++++++++++++++++++
 tb/tb_aurora_reset_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aurora_reset_seq.sv
// Reset/bring-up sequencer for an Aurora link: drives tx_reset/gt_reset, pulses start, retries on timeout.
// Optional AURORA_RELINK_EN: a filtered channel_up drop in RUN clears retry_cnt and re-runs the sequence.
module aurora_reset_seq #(
  parameter int PRE_CYCLES     = 490,
  parameter int TX_RST_CYCLES  = 100,
  parameter int GT_LOW_CYCLES  = 10,
  parameter int GT_HIGH_CYCLES = 10,
  parameter int START_CYCLES   = 3,
  parameter int UP_TIMEOUT     = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int DROP_FILTER    = 8,
  parameter int CNT_W          = 16,
  parameter int RETRY_W        = 4
) (
  input  logic               init_clk,
  input  logic               RST_N,
  input  logic               channel_up,
  output logic               tx_reset,
  output logic               gt_reset,
  output logic               start,
  output logic               link_up,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_GT_LOW  = 3'd1,
    S_GT_HIGH = 3'd2,
    S_START   = 3'd3,
    S_WAIT_UP = 3'd4,
    S_RUN     = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]   PRE_LAST   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOW_LAST   = CNT_W'(GT_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HIGH_LAST  = CNT_W'(GT_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0]   UP_LAST    = CNT_W'(UP_TIMEOUT - 1);
  localparam logic [CNT_W:0]     TX_LIM     = (CNT_W + 1)'(TX_RST_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  if (PRE_CYCLES < 1 || TX_RST_CYCLES < 1 || TX_RST_CYCLES > PRE_CYCLES || GT_LOW_CYCLES < 1 ||
      GT_HIGH_CYCLES < 1 || START_CYCLES < 1 || UP_TIMEOUT < 1 || MAX_RETRIES < 0 ||
      DROP_FILTER < 1) begin : g_param_err
    $error("aurora_reset_seq: illegal parameter set");
  end

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic [1:0]         sync_r;
  logic               up_s;
  logic [RETRY_W-1:0] retry_nx_s;
  logic               tx_nx_s, gt_nx_s, start_nx_s, link_nx_s, fail_nx_s;
`ifdef AURORA_RELINK_EN
  logic [CNT_W-1:0]   drop_cnt_r, drop_nx_s;
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_FILTER - 1);
`endif

  assign up_s = sync_r[1];

  // channel_up crosses from the user clock domain through two flops
  always_ff @(posedge init_clk or negedge RST_N) begin
    if (!RST_N) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], channel_up};
    end
  end

  // next state, retry count and the output values that go with the next state
  always_comb begin
    state_nx_s = state_r;
    retry_nx_s = retry_cnt;
`ifdef AURORA_RELINK_EN
    drop_nx_s  = '0;
`endif
    case (state_r)
      S_HOLD:    if (cnt_r == PRE_LAST)   state_nx_s = S_GT_LOW;  else state_nx_s = S_HOLD;
      S_GT_LOW:  if (cnt_r == LOW_LAST)   state_nx_s = S_GT_HIGH; else state_nx_s = S_GT_LOW;
      S_GT_HIGH: if (cnt_r == HIGH_LAST)  state_nx_s = S_START;   else state_nx_s = S_GT_HIGH;
      S_START:   if (cnt_r == START_LAST) state_nx_s = S_WAIT_UP; else state_nx_s = S_START;
      S_WAIT_UP: begin
        // a link that comes up on the timeout cycle wins over the retry
        if (up_s) begin
          state_nx_s = S_RUN;
        end else if (cnt_r == UP_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_nx_s = retry_cnt + 1'b1;
            state_nx_s = S_HOLD;
          end else begin
            state_nx_s = S_FAIL;
          end
        end else begin
          state_nx_s = S_WAIT_UP;
        end
      end
      S_RUN: begin
`ifdef AURORA_RELINK_EN
        if (!up_s) begin
          if (drop_cnt_r == DROP_LAST) begin
            state_nx_s = S_HOLD;
            retry_nx_s = '0;
          end else begin
            drop_nx_s  = drop_cnt_r + 1'b1;
            state_nx_s = S_RUN;
          end
        end else begin
          state_nx_s = S_RUN;
        end
`else
        state_nx_s = S_RUN;
`endif
      end
      S_FAIL:  state_nx_s = S_FAIL;
      default: state_nx_s = S_HOLD;
    endcase

    if (state_nx_s != state_r) cnt_nx_s = '0;
    else                       cnt_nx_s = cnt_r + 1'b1;

    tx_nx_s    = 1'b0;
    gt_nx_s    = 1'b0;
    start_nx_s = 1'b0;
    link_nx_s  = 1'b0;
    fail_nx_s  = 1'b0;
    case (state_nx_s)
      S_HOLD: begin
        gt_nx_s = 1'b1;
        tx_nx_s = ({1'b0, cnt_nx_s} < TX_LIM);
      end
      S_GT_LOW:  gt_nx_s    = 1'b0;
      S_GT_HIGH: gt_nx_s    = 1'b1;
      S_START:   start_nx_s = 1'b1;
      S_WAIT_UP: start_nx_s = 1'b0;
      S_RUN:     link_nx_s  = up_s;
      S_FAIL: begin
        tx_nx_s   = 1'b1;
        gt_nx_s   = 1'b1;
        fail_nx_s = 1'b1;
      end
      default: begin
        tx_nx_s = 1'b1;
        gt_nx_s = 1'b1;
      end
    endcase
  end

  // state, phase counter and registered outputs
  always_ff @(posedge init_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= S_HOLD;
      cnt_r     <= '0;
      tx_reset  <= 1'b1;
      gt_reset  <= 1'b1;
      start     <= 1'b0;
      link_up   <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      tx_reset  <= tx_nx_s;
      gt_reset  <= gt_nx_s;
      start     <= start_nx_s;
      link_up   <= link_nx_s;
      fail      <= fail_nx_s;
      retry_cnt <= retry_nx_s;
    end
  end

`ifdef AURORA_RELINK_EN
  // consecutive low cycles of up_s seen while in RUN
  always_ff @(posedge init_clk or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_r <= '0;
    end else begin
      drop_cnt_r <= drop_nx_s;
    end
  end
`endif

endmodule

// File: tb/tb_aurora_reset_seq.sv
// Self-checking bench for aurora_reset_seq: timeline-based reference model plus directed edge checks.
module tb_aurora_reset_seq;

  localparam int PRE = 490, TXC = 100, GL = 10, GH = 10, ST = 3, TO = 16, MAXR = 2, DF = 8;
  localparam int PH_END = PRE + GL + GH + ST;
`ifdef AURORA_RELINK_EN
  localparam bit RELINK = 1'b1;
`else
  localparam bit RELINK = 1'b0;
`endif

  logic       init_clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       channel_up = 1'b0;
  logic       tx_reset, gt_reset, start, link_up, fail;
  logic [3:0] retry_cnt;

  aurora_reset_seq #(
    .PRE_CYCLES(PRE), .TX_RST_CYCLES(TXC), .GT_LOW_CYCLES(GL), .GT_HIGH_CYCLES(GH),
    .START_CYCLES(ST), .UP_TIMEOUT(TO), .MAX_RETRIES(MAXR), .DROP_FILTER(DF),
    .CNT_W(16), .RETRY_W(4)
  ) dut (
    .init_clk(init_clk), .RST_N(RST_N), .channel_up(channel_up),
    .tx_reset(tx_reset), .gt_reset(gt_reset), .start(start),
    .link_up(link_up), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 init_clk = ~init_clk;

  int n_total = 0;
  int n_pass  = 0;
  int e = 0;
  bit hist [0:8191];

  // reference model: mode 0 = sequencing (timeline offset from seq start), 1 = running, 2 = failed
  int m_mode, m_seq, m_retry, m_drop;
  logic [8:0] m_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, expv);
  endtask

  task automatic model_reset();
    e = 0; m_mode = 0; m_seq = 0; m_retry = 0; m_drop = 0;
  endtask

  task automatic model_edge();
    bit upv;
    int d;
    bit xtx, xgt, xst, xlk, xfl;
    upv = (e >= 3) ? hist[e-2] : 1'b0;
    if (m_mode == 0) begin
      d = e - m_seq;
      if (d > PH_END) begin
        if (upv) m_mode = 1;
        else if (d - PH_END == TO) begin
          if (m_retry < MAXR) begin m_retry++; m_seq = e; end
          else m_mode = 2;
        end
      end
    end else if (m_mode == 1 && RELINK) begin
      if (!upv) begin
        m_drop++;
        if (m_drop == DF) begin m_mode = 0; m_seq = e; m_retry = 0; m_drop = 0; end
      end else m_drop = 0;
    end
    xtx = 0; xgt = 0; xst = 0; xlk = 0; xfl = 0;
    if (m_mode == 0) begin
      d = e - m_seq;
      xtx = (d < TXC);
      xgt = (d < PRE) || (d >= PRE + GL && d < PRE + GL + GH);
      xst = (d >= PRE + GL + GH && d < PH_END);
    end else if (m_mode == 1) begin
      xlk = upv;
    end else begin
      xtx = 1; xgt = 1; xfl = 1;
    end
    m_exp = {xtx, xgt, xst, xlk, xfl, 4'(m_retry)};
  endtask

  task automatic step();
    @(posedge init_clk);
    e++;
    hist[e] = channel_up;
    model_edge();
    #1;
    chk("outs", {23'd0, tx_reset, gt_reset, start, link_up, fail, retry_cnt}, {23'd0, m_exp});
  endtask

  task automatic do_reset(input logic ch);
    @(negedge init_clk);
    RST_N = 1'b0;
    channel_up = ch;
    #1;
    chk("reset_vals", {23'd0, tx_reset, gt_reset, start, link_up, fail, retry_cnt}, {23'd0, 9'b110000000});
    @(negedge init_clk);
    RST_N = 1'b1;
    model_reset();
  endtask

  int tx_fall, gt_fall1, gt_rise1, gt_fall2, st_rise, st_fall, lk_fall, lk_rise, gt_falls, st_rises;
  logic p_tx, p_gt, p_st, p_lk;
  int hold;

  initial begin
    // --- default bring-up with channel_up high from the start, then drops in RUN
    do_reset(1'b1);
    tx_fall = -1; gt_fall1 = -1; gt_rise1 = -1; gt_fall2 = -1; st_rise = -1; st_fall = -1;
    lk_fall = -1; lk_rise = -1; gt_falls = 0;
    p_tx = 1; p_gt = 1; p_st = 0; p_lk = 0;
    while (e < 1200) begin
      step();
      if (p_tx && !tx_reset && tx_fall < 0) tx_fall = e;
      if (p_gt && !gt_reset) begin
        if (gt_fall1 < 0) gt_fall1 = e; else if (gt_fall2 < 0) gt_fall2 = e;
        if (e > 560) gt_falls++;
      end
      if (!p_gt && gt_reset && gt_rise1 < 0) gt_rise1 = e;
      if (!p_st && start && st_rise < 0) st_rise = e;
      if (p_st && !start && st_fall < 0) st_fall = e;
      if (e > 560 && p_lk && !link_up && lk_fall < 0) lk_fall = e;
      if (e > 563 && !p_lk && link_up && lk_rise < 0) lk_rise = e;
      p_tx = tx_reset; p_gt = gt_reset; p_st = start; p_lk = link_up;
      if (e == 540) channel_up = 1'b0;
      if (e == 545) channel_up = 1'b1;
      if (e == 555) chk("short_drop_link", {31'd0, link_up}, 32'd1);
      if (e == 560) channel_up = 1'b0;
      if (e == 580) channel_up = 1'b1;
    end
    chk("tx_fall", tx_fall, 100);
    chk("gt_fall1", gt_fall1, 490);
    chk("gt_rise1", gt_rise1, 500);
    chk("gt_fall2", gt_fall2, 510);
    chk("start_rise", st_rise, 510);
    chk("start_fall", st_fall, 513);
    chk("drop_link_fall", lk_fall, 563);
    chk("drop_link_rise", lk_rise, RELINK ? 1084 : 583);
    chk("drop_gt_falls", gt_falls, RELINK ? 2 : 0);
    chk("drop_retry", {28'd0, retry_cnt}, 32'd0);

    // --- channel_up never rises: two retries then sticky FAIL
    do_reset(1'b0);
    while (e < 3 * (PH_END + TO) + 1000) begin
      step();
      if (e == PH_END + TO)           chk("retry_first", {28'd0, retry_cnt}, 32'd1);
      if (e == 2 * (PH_END + TO))     chk("retry_second", {28'd0, retry_cnt}, 32'd2);
      if (e == 3 * (PH_END + TO) - 1) chk("pre_fail", {31'd0, fail}, 32'd0);
      if (e == 3 * (PH_END + TO))     chk("fail_enter", {31'd0, fail}, 32'd1);
    end
    chk("fail_hold", {28'd0, tx_reset, gt_reset, fail, start}, 32'he);
    chk("fail_retry", {28'd0, retry_cnt}, 32'd2);

    // --- up_s first high on the exact timeout cycle: RUN, no retry, no second start
    do_reset(1'b0);
    st_rises = 0; p_st = 0;
    while (e < 1100) begin
      step();
      if (e > PH_END && !p_st && start) st_rises++;
      p_st = start;
      if (e == PH_END + TO - 3) channel_up = 1'b1;
      if (e == PH_END + TO) chk("race_link", {28'd0, retry_cnt}, {28'd0, 4'd0});
      if (e == PH_END + TO) chk("race_run", {31'd0, link_up}, 32'd1);
    end
    chk("race_no_restart", st_rises, 0);

    // --- async reset pulse during GT_LOW, then restart timeline
    do_reset(1'b1);
    while (e < 495) step();
    chk("in_gt_low", {31'd0, gt_reset}, 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_gt", {31'd0, gt_reset}, 32'd1);
    chk("async_tx", {31'd0, tx_reset}, 32'd1);
    @(posedge init_clk);
    #2;
    RST_N = 1'b1;
    model_reset();
    tx_fall = -1; p_tx = 1;
    while (e < 120) begin
      step();
      if (p_tx && !tx_reset && tx_fall < 0) tx_fall = e;
      p_tx = tx_reset;
    end
    chk("restart_tx_fall", tx_fall, 100);

    // --- randomized channel_up activity against the model
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(0, 1) == 1);
      hold = $urandom_range(1, 600);
      while (e < 1500) begin
        step();
        hold--;
        if (hold <= 0) begin
          channel_up = ~channel_up;
          hold = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 900) : $urandom_range(1, 14);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
